// File: rtl/rsa_dmem_responder.sv
// Data-memory responder for the RSA core: word RAM, a small MMIO block, a host loader port
// and the run/done sequencer that drives the core's start signal.
module rsa_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        start,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,
  input  logic        host_go,
  output logic        done,
  output logic [31:0] cycles
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RamBytes   = 32'(DEPTH_WORDS * 4);
  localparam logic [29:0] StatusWord = MMIO_BASE[31:2];
  localparam logic [29:0] DoneWord   = MMIO_BASE[31:2] + 30'd1;
  localparam logic [29:0] CyclesWord = MMIO_BASE[31:2] + 30'd2;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic        done_q;
  logic [31:0] cycles_q;
  logic [31:0] host_rdata_q;
  logic        host_rvalid_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] core_idx;
  logic [AW-1:0] host_idx;
  logic [31:0]   status_word;
  logic [31:0]   host_rd_word;
  logic          running;
  logic          host_acc;
  logic          core_ram_wr;
  logic          host_ram_wr;
  logic          core_done_wr;

  // Shared read decode: RAM below RamBytes, the two readable MMIO words, zero elsewhere.
  function automatic logic [31:0] decode(input logic [31:0] addr, input logic [31:0] ram_word,
                                         input logic [31:0] status, input logic [31:0] cyc);
    if (addr < RamBytes) return ram_word;
    if (addr[31:2] == StatusWord) return status;
    if (addr[31:2] == CyclesWord) return cyc;
    return '0;
  endfunction

  always_comb begin
    running      = (state_q == StRun);
    core_idx     = ALUResult[AW+1:2];
    host_idx     = host_addr[AW+1:2];
    status_word  = {30'd0, running, done_q};
    host_acc     = host_valid && !running;
    core_ram_wr  = running && MemWrite && (ALUResult < RamBytes);
    host_ram_wr  = host_acc && host_we && (host_addr < RamBytes);
    core_done_wr = running && MemWrite && (ALUResult[31:2] == DoneWord);
    ReadData     = decode(ALUResult, mem[core_idx], status_word, cycles_q);
    host_rd_word = decode(host_addr, mem[host_idx], status_word, cycles_q);
  end

  assign start       = running;
  assign host_ready  = !running;
  assign done        = done_q;
  assign cycles      = cycles_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;

  // RAM keeps its contents across reset; core and host writes never coincide.
  always_ff @(posedge clk) begin
    if (core_ram_wr) begin
      mem[core_idx] <= WriteData;
    end else if (host_ram_wr) begin
      mem[host_idx] <= host_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      done_q        <= 1'b0;
      cycles_q      <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      host_rvalid_q <= host_acc && !host_we;
      if (host_acc && !host_we) begin
        host_rdata_q <= host_rd_word;
      end
      case (state_q)
        StIdle, StDone: begin
          if (host_go) begin
            state_q  <= StRun;
            done_q   <= 1'b0;
            cycles_q <= '0;
          end
        end
        StRun: begin
          if (cycles_q != 32'hFFFF_FFFF) begin
            cycles_q <= cycles_q + 32'd1;
          end
          if (core_done_wr) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
